nes_oam_dma: RTL and testbench

Sprite DMA controller on the CPU bus, next to the 6502 core. A CPU write to the DMA register starts the transfer. The block then stalls the core through its `rdy` input and copies 256 bytes from CPU page `$XX00–$XXFF` to the PPU OAM data port. While the transfer runs, a top-level mux selects the DMA's address and data outputs in place of the CPU's.

---
 rtl/nes_bus_pkg.sv | 15 +
 rtl/nes_oam_dma.sv | 149 ++++++++++++++
 tb/tb_nes_oam_dma.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: register addresses and the OAM DMA state encoding.
package nes_bus_pkg;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/nes_oam_dma.sv
// Sprite DMA: halts the 6502 via rdy and copies page $XX00-$XXFF to the OAM data port,
// one get/put cycle pair per byte.
module nes_oam_dma
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = ADDR_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR = ADDR_OAMDATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ph1_rising,
    input  logic        ph2_falling,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_db_out,
    input  logic        cpu_read,
    input  logic [7:0]  db_in,
    output logic        rdy,
    output logic        dma_en,
    output logic [15:0] dma_ab,
    output logic [7:0]  dma_db_out,
    output logic        dma_read,
    output logic        busy
);

    dma_state_e  state_q, state_d;
    logic        put_q, put_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        halted_q, halted_d;
    logic        rdy_q, rdy_d;
    logic        busy_q, busy_d;
    logic        dma_en_q, dma_en_d;
    logic [15:0] dma_ab_q, dma_ab_d;
    logic [7:0]  dma_db_out_q, dma_db_out_d;
    logic        dma_read_q, dma_read_d;

    always_comb begin
        state_d      = state_q;
        put_d        = put_q;
        page_d       = page_q;
        idx_d        = idx_q;
        data_d       = data_q;
        halted_d     = halted_q;
        rdy_d        = rdy_q;
        busy_d       = busy_q;
        dma_en_d     = dma_en_q;
        dma_ab_d     = dma_ab_q;
        dma_db_out_d = dma_db_out_q;
        dma_read_d   = dma_read_q;

        // Bus-driving outputs change at the start of a CPU cycle, like the CPU's own.
        if (ph1_rising) begin
            case (state_q)
                ST_HALT: begin
                    dma_en_d = 1'b0;
                    if (cpu_read) halted_d = 1'b1;
                end
                ST_READ: begin
                    dma_en_d   = 1'b1;
                    dma_ab_d   = {page_q, idx_q};
                    dma_read_d = 1'b1;
                end
                ST_WRITE: begin
                    dma_ab_d     = OAM_DATA_ADDR;
                    dma_db_out_d = data_q;
                    dma_read_d   = 1'b0;
                end
                default: dma_en_d = 1'b0;
            endcase
        end

        // Sequencing advances at the end of a CPU cycle, when the bus is sampled.
        if (ph2_falling) begin
            put_d = ~put_q;
            case (state_q)
                ST_IDLE: begin
                    if (!cpu_read && cpu_ab == DMA_REG_ADDR) begin
                        page_d  = cpu_db_out;
                        idx_d   = 8'h00;
                        rdy_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (halted_q) state_d = put_q ? ST_READ : ST_ALIGN;
                end
                ST_ALIGN: state_d = ST_READ;
                ST_READ: begin
                    data_d  = db_in;
                    state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    if (idx_q == 8'hFF) begin
                        rdy_d    = 1'b1;
                        busy_d   = 1'b0;
                        halted_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = ST_READ;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            put_q        <= 1'b0;
            page_q       <= 8'h00;
            idx_q        <= 8'h00;
            halted_q     <= 1'b0;
            rdy_q        <= 1'b1;
            busy_q       <= 1'b0;
            dma_en_q     <= 1'b0;
            dma_ab_q     <= 16'h0000;
            dma_db_out_q <= 8'h00;
            dma_read_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            put_q        <= put_d;
            page_q       <= page_d;
            idx_q        <= idx_d;
            halted_q     <= halted_d;
            rdy_q        <= rdy_d;
            busy_q       <= busy_d;
            dma_en_q     <= dma_en_d;
            dma_ab_q     <= dma_ab_d;
            dma_db_out_q <= dma_db_out_d;
            dma_read_q   <= dma_read_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign rdy        = rdy_q;
    assign dma_en     = dma_en_q;
    assign dma_ab     = dma_ab_q;
    assign dma_db_out = dma_db_out_q;
    assign dma_read   = dma_read_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_nes_oam_dma.sv
// Bench for nes_oam_dma: a CPU-cycle driver with a random memory image and a
// transfer-level reference (256 reads of {page,i}, each followed by an OAM write of that byte).
module tb_nes_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        ph1_rising, ph2_falling;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_db_out;
    logic        cpu_read;
    logic [7:0]  db_in;
    logic        rdy, dma_en, dma_read, busy;
    logic [15:0] dma_ab;
    logic [7:0]  dma_db_out;

    nes_oam_dma dut (
        .clk        (clk),
        .rst        (rst),
        .ph1_rising (ph1_rising),
        .ph2_falling(ph2_falling),
        .cpu_ab     (cpu_ab),
        .cpu_db_out (cpu_db_out),
        .cpu_read   (cpu_read),
        .db_in      (db_in),
        .rdy        (rdy),
        .dma_en     (dma_en),
        .dma_ab     (dma_ab),
        .dma_db_out (dma_db_out),
        .dma_read   (dma_read),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0]  mem [65536];
    logic [15:0] rd_q [$];
    logic [15:0] wr_ab_q [$];
    logic [7:0]  wr_d_q [$];

    bit   put_m;
    logic cyc_rdy, cyc_en, cyc_read, cyc_busy;

    task automatic tb_chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One CPU cycle: ph1 clk, idle clk, ph2 clk, idle clk. Observes the muxed bus before ph2.
    task automatic cpu_cycle(input logic [15:0] a, input logic rd, input logic [7:0] wd);
        logic [15:0] bab;
        logic        brd;
        @(negedge clk);
        cpu_ab = a; cpu_read = rd; cpu_db_out = wd; ph1_rising = 1'b1;
        cyc_rdy = rdy;
        @(negedge clk);
        ph1_rising = 1'b0;
        @(negedge clk);
        bab = dma_en ? dma_ab : cpu_ab;
        brd = dma_en ? dma_read : cpu_read;
        db_in = brd ? mem[bab] : 8'h00;
        cyc_en = dma_en; cyc_read = dma_read; cyc_busy = busy;
        if (dma_en) begin
            if (dma_read) rd_q.push_back(dma_ab);
            else begin
                wr_ab_q.push_back(dma_ab);
                wr_d_q.push_back(dma_db_out);
            end
        end
        ph2_falling = 1'b1;
        @(negedge clk);
        ph2_falling = 1'b0;
        put_m = ~put_m;
    endtask

    task automatic run_dma(input logic [7:0] pg, input int nwr, input bit halt_put,
                           input bit retrig, input bit abort);
        int stolen, align;
        bit done;
        // The halt lands on the first read after the trigger; pad one cycle to pick its parity.
        if ((put_m ^ bit'((nwr + 1) & 1)) != halt_put) cpu_cycle(16'h0000, 1'b1, 8'h00);
        rd_q.delete(); wr_ab_q.delete(); wr_d_q.delete();
        cpu_cycle(16'h4014, 1'b0, pg);
        tb_chk("trig_busy", busy, 1);
        tb_chk("trig_rdy", rdy, 0);
        for (int i = 0; i < nwr; i++) begin
            cpu_cycle(16'h0010 + 16'(i), 1'b0, 8'($urandom));
            tb_chk("wr_pass_en", cyc_en, 0);
            tb_chk("wr_pass_rdy", cyc_rdy, 0);
        end
        stolen = 0; align = 0; done = 1'b0;
        for (int k = 0; k < 700 && !done; k++) begin
            if (retrig && k == 40) cpu_cycle(16'h4014, 1'b0, 8'h07);
            else cpu_cycle(16'h8000, 1'b1, 8'h00);
            if (cyc_rdy) done = 1'b1;
            else begin
                stolen++;
                if (k > 0 && !cyc_en) align++;
            end
            if (abort && rd_q.size() == 101) begin
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                tb_chk("abort_rdy", rdy, 1);
                tb_chk("abort_en", dma_en, 0);
                tb_chk("abort_busy", busy, 0);
                rst = 1'b1;
                put_m = 1'b0;
                return;
            end
        end
        tb_chk("dma_done", done, 1);
        tb_chk("stolen", stolen, halt_put ? 513 : 514);
        tb_chk("align", align, halt_put ? 0 : 1);
        tb_chk("end_en", cyc_en, 0);
        tb_chk("end_busy", cyc_busy, 0);
        tb_chk("n_reads", rd_q.size(), 256);
        tb_chk("n_writes", wr_d_q.size(), 256);
        for (int i = 0; i < 256; i++) begin
            if (i < rd_q.size()) tb_chk("rd_addr", rd_q[i], {pg, 8'(i)});
            if (i < wr_d_q.size()) begin
                tb_chk("wr_addr", wr_ab_q[i], 16'h2004);
                tb_chk("wr_data", wr_d_q[i], mem[{pg, 8'(i)}]);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        rst = 1'b0; ph1_rising = 1'b0; ph2_falling = 1'b0;
        cpu_ab = 16'h0000; cpu_db_out = 8'h00; cpu_read = 1'b1; db_in = 8'h00;
        put_m = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        tb_chk("rst_rdy", rdy, 1);
        tb_chk("rst_en", dma_en, 0);
        tb_chk("rst_read", dma_read, 1);
        tb_chk("rst_busy", busy, 0);
        tb_chk("rst_ab", dma_ab, 16'h0000);
        tb_chk("rst_dbo", dma_db_out, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cpu_cycle(16'h0000, 1'b1, 8'h00);
            tb_chk("idle_rdy", cyc_rdy, 1);
            tb_chk("idle_en", cyc_en, 0);
            tb_chk("idle_read", cyc_read, 1);
            tb_chk("idle_busy", cyc_busy, 0);
        end

        run_dma(8'h02, 0, 1'b1, 1'b0, 1'b0);
        run_dma(8'h02, 0, 1'b0, 1'b0, 1'b0);
        run_dma(8'($urandom), 2, 1'($urandom), 1'b0, 1'b0);
        run_dma(8'h03, 0, 1'b1, 1'b1, 1'b0);
        run_dma(8'($urandom), 0, 1'b1, 1'b0, 1'b1);
        run_dma(8'h05, 1, 1'b0, 1'b0, 1'b0);
        run_dma(8'h40, 0, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 2; t++)
            run_dma(8'($urandom), int'($urandom_range(0, 2)), 1'($urandom), 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
